// File: rtl/soc_decode_bb_pkg.sv
// Shared types and constants for the Blackbone address decoder.
package soc_decode_bb_pkg;

  localparam int MAX_SLAVES = 16;
  localparam int IDX_MAX_W  = 4;

  // Default read value returned for unmapped or multi-hit reads
  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

  // Width of a slave index for n slaves (at least one bit)
  function automatic int idx_w(input int n);
    if (n <= 1) return 1;
    return $clog2(n);
  endfunction

  // One in-flight response slot; idx is sized for the largest slave count
  typedef struct packed {
    logic                 valid;
    logic                 is_read;
    logic                 err;
    logic [IDX_MAX_W-1:0] idx;
  } rsp_entry_t;

endpackage

// File: rtl/soc_decode_bb_match.sv
// Combinational base/mask window compare. Lowest-index hit wins; zero or
// multiple hits flag an error. A slave with an all-zero mask never hits.
module soc_decode_bb_match
  import soc_decode_bb_pkg::*;
#(
  parameter int SLAVES     = 4,
  parameter int ADDR_WIDTH = 32,
  parameter logic [SLAVES-1:0][ADDR_WIDTH-1:0] S_BASE = '0,
  parameter logic [SLAVES-1:0][ADDR_WIDTH-1:0] S_MASK = '0,
  parameter int IDX_W      = idx_w(SLAVES)
) (
  input  logic [ADDR_WIDTH-1:0] addr_i,
  output logic [SLAVES-1:0]     onehot_o,
  output logic [IDX_W-1:0]      idx_o,
  output logic                  err_o
);

  logic [SLAVES-1:0] hit_vec;
  logic [4:0]        hit_cnt;
  logic              found;

  // Window compare, hit count and lowest-index winner selection
  always_comb begin
    hit_vec  = '0;
    hit_cnt  = '0;
    found    = 1'b0;
    onehot_o = '0;
    idx_o    = '0;
    for (int i = 0; i < SLAVES; i++) begin
      hit_vec[i] = (S_MASK[i] != '0) &&
                   ((addr_i & S_MASK[i]) == (S_BASE[i] & S_MASK[i]));
      if (hit_vec[i]) begin
        hit_cnt = hit_cnt + 5'd1;
        if (!found) begin
          found       = 1'b1;
          onehot_o[i] = 1'b1;
          idx_o       = IDX_W'(i);
        end
      end
    end
    err_o = (hit_cnt != 5'd1);
  end

endmodule

// File: rtl/soc_decode_bb_pipe.sv
// Pipelined Blackbone address decoder: one master, up to 16 slaves.
// Optional error address capture is enabled by SOC_DECODE_BB_ERR_CAPTURE_EN.
module soc_decode_bb_pipe
  import soc_decode_bb_pkg::*;
#(
  parameter int SLAVES       = 4,
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter logic [SLAVES-1:0][ADDR_WIDTH-1:0] S_BASE = '0,
  parameter logic [SLAVES-1:0][ADDR_WIDTH-1:0] S_MASK = '0,
  parameter int READ_LATENCY = 1,
  parameter int PIPE_REQ     = 0,
  parameter logic [31:0] ERR_DATA = ERR_DATA_DEFAULT,
  localparam int SEL_WIDTH   = DATA_WIDTH / 8
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [ADDR_WIDTH-1:0]                m_addr_i,
  input  logic [DATA_WIDTH-1:0]                m_din_i,
  input  logic [SEL_WIDTH-1:0]                 m_be_i,
  input  logic                                 m_en_i,
  input  logic                                 m_we_i,
  output logic [DATA_WIDTH-1:0]                m_dout_o,
  output logic                                 m_valid_o,
  output logic                                 m_err_o,
  output logic [SLAVES-1:0][ADDR_WIDTH-1:0]    s_addr_o,
  output logic [SLAVES-1:0][DATA_WIDTH-1:0]    s_din_o,
  output logic [SLAVES-1:0][SEL_WIDTH-1:0]     s_be_o,
  output logic [SLAVES-1:0]                    s_en_o,
  output logic [SLAVES-1:0]                    s_we_o,
  input  logic [SLAVES-1:0][DATA_WIDTH-1:0]    s_dout_i,
  input  logic                                 err_clr_i,
  output logic [ADDR_WIDTH-1:0]                err_addr_o,
  output logic                                 err_sticky_o
);

  localparam int IDX_W = idx_w(SLAVES);
  localparam logic [DATA_WIDTH-1:0] ERR_DATA_W = DATA_WIDTH'(ERR_DATA);

  logic [SLAVES-1:0] mt_onehot;
  logic [IDX_W-1:0]  mt_idx;
  logic              mt_err;

  soc_decode_bb_match #(
    .SLAVES     (SLAVES),
    .ADDR_WIDTH (ADDR_WIDTH),
    .S_BASE     (S_BASE),
    .S_MASK     (S_MASK),
    .IDX_W      (IDX_W)
  ) u_match (
    .addr_i   (m_addr_i),
    .onehot_o (mt_onehot),
    .idx_o    (mt_idx),
    .err_o    (mt_err)
  );

  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_din;
  logic [SEL_WIDTH-1:0]  req_be;
  logic                  req_en;
  logic                  req_we;
  logic [SLAVES-1:0]     req_onehot;
  logic [IDX_W-1:0]      req_idx;
  logic                  req_err;

  generate
    if (PIPE_REQ != 0) begin : g_req_reg
      logic [ADDR_WIDTH-1:0] addr_q;
      logic [DATA_WIDTH-1:0] din_q;
      logic [SEL_WIDTH-1:0]  be_q;
      logic                  en_q;
      logic                  we_q;
      logic [SLAVES-1:0]     onehot_q;
      logic [IDX_W-1:0]      idx_q;
      logic                  err_q;

      // Request register: master fields plus the decode result
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          addr_q   <= '0;
          din_q    <= '0;
          be_q     <= '0;
          en_q     <= 1'b0;
          we_q     <= 1'b0;
          onehot_q <= '0;
          idx_q    <= '0;
          err_q    <= 1'b0;
        end else begin
          addr_q   <= m_addr_i;
          din_q    <= m_din_i;
          be_q     <= m_be_i;
          en_q     <= m_en_i;
          we_q     <= m_we_i;
          onehot_q <= mt_onehot;
          idx_q    <= mt_idx;
          err_q    <= mt_err;
        end
      end

      assign req_addr   = addr_q;
      assign req_din    = din_q;
      assign req_be     = be_q;
      assign req_en     = en_q;
      assign req_we     = we_q;
      assign req_onehot = onehot_q;
      assign req_idx    = idx_q;
      assign req_err    = err_q;
    end else begin : g_req_comb
      // Pass-through stage; forced to zero while reset is held so every
      // output reads zero during reset
      assign req_addr   = rst_i ? '0   : m_addr_i;
      assign req_din    = rst_i ? '0   : m_din_i;
      assign req_be     = rst_i ? '0   : m_be_i;
      assign req_en     = rst_i ? 1'b0 : m_en_i;
      assign req_we     = rst_i ? 1'b0 : m_we_i;
      assign req_onehot = rst_i ? '0   : mt_onehot;
      assign req_idx    = rst_i ? '0   : mt_idx;
      assign req_err    = rst_i ? 1'b0 : mt_err;
    end
  endgenerate

  // Slave fan-out: shared bus fields, strobe only to an error-free winner
  genvar gi;
  generate
    for (gi = 0; gi < SLAVES; gi++) begin : g_fan
      assign s_addr_o[gi] = req_addr;
      assign s_din_o[gi]  = req_din;
      assign s_be_o[gi]   = req_be;
      assign s_we_o[gi]   = req_we;
      assign s_en_o[gi]   = req_en & req_onehot[gi] & ~req_err;
    end
  endgenerate

  rsp_entry_t rsp_push_d;
  rsp_entry_t rsp_q [READ_LATENCY];
  rsp_entry_t rsp_out;

  // Entry describing the request issued to the slaves this cycle
  always_comb begin
    rsp_push_d         = '0;
    rsp_push_d.valid   = req_en;
    rsp_push_d.is_read = req_en & ~req_we;
    rsp_push_d.err     = req_en & req_err;
    rsp_push_d.idx     = IDX_MAX_W'(req_idx);
  end

  // Response tracking shift register, READ_LATENCY deep
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < READ_LATENCY; i++) rsp_q[i] <= '0;
    end else begin
      rsp_q[0] <= rsp_push_d;
      for (int i = 1; i < READ_LATENCY; i++) rsp_q[i] <= rsp_q[i-1];
    end
  end

  assign rsp_out = rsp_q[READ_LATENCY-1];

  logic [DATA_WIDTH-1:0] rd_data;
  logic [DATA_WIDTH-1:0] dout_q;

  // Slave read data arrives registered by the slave itself in the response
  // slot, so it is muxed straight out; dout_q keeps the last value shown.
  assign rd_data   = rsp_out.err ? ERR_DATA_W : s_dout_i[rsp_out.idx[IDX_W-1:0]];
  assign m_valid_o = rsp_out.valid & rsp_out.is_read;
  assign m_err_o   = rsp_out.valid & rsp_out.err;
  assign m_dout_o  = m_valid_o ? rd_data : dout_q;

  // Hold register for read data between valid pulses
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)          dout_q <= '0;
    else if (m_valid_o) dout_q <= rd_data;
  end

  logic unused_rsp_idx;
  assign unused_rsp_idx = ^rsp_out.idx;

`ifdef SOC_DECODE_BB_ERR_CAPTURE_EN
  logic [ADDR_WIDTH-1:0] addr_pipe_q [READ_LATENCY];
  logic [ADDR_WIDTH-1:0] err_addr_q, err_addr_d;
  logic                  err_sticky_q, err_sticky_d;

  // Request addresses travel alongside the response entries
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < READ_LATENCY; i++) addr_pipe_q[i] <= '0;
    end else begin
      addr_pipe_q[0] <= req_addr;
      for (int i = 1; i < READ_LATENCY; i++) addr_pipe_q[i] <= addr_pipe_q[i-1];
    end
  end

  // First error is kept; a clear coinciding with a new error keeps the new one
  always_comb begin
    err_addr_d   = err_addr_q;
    err_sticky_d = err_sticky_q;
    if (err_clr_i) begin
      err_addr_d   = '0;
      err_sticky_d = 1'b0;
    end
    if (m_err_o && (!err_sticky_q || err_clr_i)) begin
      err_addr_d   = addr_pipe_q[READ_LATENCY-1];
      err_sticky_d = 1'b1;
    end
  end

  // Captured error registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_addr_q   <= '0;
      err_sticky_q <= 1'b0;
    end else begin
      err_addr_q   <= err_addr_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  assign err_addr_o   = err_addr_q;
  assign err_sticky_o = err_sticky_q;
`else
  assign err_addr_o   = '0;
  assign err_sticky_o = 1'b0;

  logic unused_err_clr;
  assign unused_err_clr = err_clr_i;
`endif

endmodule

// File: tb/tb_soc_decode_bb_pipe.sv
// Directed bench for soc_decode_bb_pipe. Three instances share the master
// bus: A (latency 1, comb request), C (as A but S3 mask 0xF000 to make
// 0x8000 a multi-hit), B (latency 3, registered request).
module tb_soc_decode_bb_pipe;

  localparam logic [3:0][15:0] BASE   = {16'h8800, 16'h8000, 16'h4000, 16'h0000};
  localparam logic [3:0][15:0] MASK_A = {16'hF800, 16'hF000, 16'hC000, 16'hC000};
  localparam logic [3:0][15:0] MASK_C = {16'hF000, 16'hF000, 16'hC000, 16'hC000};

  logic             clk = 1'b0;
  logic             rst;
  logic [15:0]      m_addr;
  logic [31:0]      m_din;
  logic [3:0]       m_be;
  logic             m_en, m_we, err_clr;
  logic [3:0][31:0] sdout;

  logic [31:0] a_dout, b_dout, c_dout;
  logic        a_valid, b_valid, c_valid, a_err, b_err, c_err;
  logic [3:0][15:0] a_saddr, b_saddr, c_saddr;
  logic [3:0][31:0] a_sdin, b_sdin, c_sdin;
  logic [3:0][3:0]  a_sbe, b_sbe, c_sbe;
  logic [3:0]  a_sen, b_sen, c_sen, a_swe, b_swe, c_swe;
  logic [15:0] a_eaddr, b_eaddr, c_eaddr;
  logic        a_est, b_est, c_est;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  soc_decode_bb_pipe #(.SLAVES(4), .ADDR_WIDTH(16), .DATA_WIDTH(32), .S_BASE(BASE),
    .S_MASK(MASK_A), .READ_LATENCY(1), .PIPE_REQ(0)) dut_a (
    .clk_i(clk), .rst_i(rst), .m_addr_i(m_addr), .m_din_i(m_din), .m_be_i(m_be),
    .m_en_i(m_en), .m_we_i(m_we), .m_dout_o(a_dout), .m_valid_o(a_valid), .m_err_o(a_err),
    .s_addr_o(a_saddr), .s_din_o(a_sdin), .s_be_o(a_sbe), .s_en_o(a_sen), .s_we_o(a_swe),
    .s_dout_i(sdout), .err_clr_i(err_clr), .err_addr_o(a_eaddr), .err_sticky_o(a_est));

  soc_decode_bb_pipe #(.SLAVES(4), .ADDR_WIDTH(16), .DATA_WIDTH(32), .S_BASE(BASE),
    .S_MASK(MASK_A), .READ_LATENCY(3), .PIPE_REQ(1)) dut_b (
    .clk_i(clk), .rst_i(rst), .m_addr_i(m_addr), .m_din_i(m_din), .m_be_i(m_be),
    .m_en_i(m_en), .m_we_i(m_we), .m_dout_o(b_dout), .m_valid_o(b_valid), .m_err_o(b_err),
    .s_addr_o(b_saddr), .s_din_o(b_sdin), .s_be_o(b_sbe), .s_en_o(b_sen), .s_we_o(b_swe),
    .s_dout_i(sdout), .err_clr_i(err_clr), .err_addr_o(b_eaddr), .err_sticky_o(b_est));

  soc_decode_bb_pipe #(.SLAVES(4), .ADDR_WIDTH(16), .DATA_WIDTH(32), .S_BASE(BASE),
    .S_MASK(MASK_C), .READ_LATENCY(1), .PIPE_REQ(0)) dut_c (
    .clk_i(clk), .rst_i(rst), .m_addr_i(m_addr), .m_din_i(m_din), .m_be_i(m_be),
    .m_en_i(m_en), .m_we_i(m_we), .m_dout_o(c_dout), .m_valid_o(c_valid), .m_err_o(c_err),
    .s_addr_o(c_saddr), .s_din_o(c_sdin), .s_be_o(c_sbe), .s_en_o(c_sen), .s_we_o(c_swe),
    .s_dout_i(sdout), .err_clr_i(err_clr), .err_addr_o(c_eaddr), .err_sticky_o(c_est));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] addr, input logic we,
                       input logic [31:0] din, input logic [3:0] be);
    m_addr = addr; m_we = we; m_din = din; m_be = be; m_en = 1'b1;
  endtask

  task automatic idle();
    m_en = 1'b0; m_we = 1'b0; m_addr = '0; m_din = '0; m_be = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    repeat (2) tick();
    drive(16'h4010, 1'b0, 32'h0, 4'hF);
    #1;
    checks++; if (a_sen !== 4'b0000) $display("FAIL rst_sen actual=%b required=0000", a_sen); else passed++;
    checks++; if (a_saddr[1] !== 16'h0) $display("FAIL rst_saddr actual=%h required=0000", a_saddr[1]); else passed++;
    checks++; if (a_valid !== 1'b0 || a_err !== 1'b0) $display("FAIL rst_valid_err actual=%b%b required=00", a_valid, a_err); else passed++;
    checks++; if (a_dout !== 32'h0) $display("FAIL rst_dout actual=%h required=00000000", a_dout); else passed++;
    checks++; if (a_est !== 1'b0 || a_eaddr !== 16'h0) $display("FAIL rst_errcap actual=%b/%h required=0/0000", a_est, a_eaddr); else passed++;
    checks++; if (b_sen !== 4'b0000 || b_valid !== 1'b0) $display("FAIL rst_b actual=%b/%b required=0000/0", b_sen, b_valid); else passed++;
    idle();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_read();
    sdout[1] = 32'h1234_5678;
    drive(16'h4010, 1'b0, 32'h0, 4'hF);
    #1;
    checks++; if (a_sen !== 4'b0010) $display("FAIL read_sen actual=%b required=0010", a_sen); else passed++;
    checks++; if (a_saddr[1] !== 16'h4010) $display("FAIL read_saddr actual=%h required=4010", a_saddr[1]); else passed++;
    tick();
    idle();
    checks++; if (a_valid !== 1'b1) $display("FAIL read_valid actual=%b required=1", a_valid); else passed++;
    checks++; if (a_dout !== 32'h1234_5678) $display("FAIL read_dout actual=%h required=12345678", a_dout); else passed++;
    checks++; if (a_err !== 1'b0) $display("FAIL read_err actual=%b required=0", a_err); else passed++;
    tick();
    checks++; if (a_valid !== 1'b0) $display("FAIL read_pulse actual=%b required=0", a_valid); else passed++;
    checks++; if (a_dout !== 32'h1234_5678) $display("FAIL read_hold actual=%h required=12345678", a_dout); else passed++;
  endtask

  task automatic test_write();
    drive(16'h0004, 1'b1, 32'hA5A5_A5A5, 4'b0011);
    #1;
    checks++; if (a_sen !== 4'b0001) $display("FAIL wr_sen actual=%b required=0001", a_sen); else passed++;
    checks++; if (a_swe[0] !== 1'b1) $display("FAIL wr_swe actual=%b required=1", a_swe[0]); else passed++;
    checks++; if (a_sbe[0] !== 4'b0011) $display("FAIL wr_sbe actual=%b required=0011", a_sbe[0]); else passed++;
    checks++; if (a_sdin[2] !== 32'hA5A5_A5A5) $display("FAIL wr_bcast_din actual=%h required=a5a5a5a5", a_sdin[2]); else passed++;
    tick();
    idle();
    checks++; if (a_valid !== 1'b0 || a_err !== 1'b0) $display("FAIL wr_rsp actual=%b%b required=00", a_valid, a_err); else passed++;
    checks++; if (a_dout !== 32'h1234_5678) $display("FAIL wr_hold actual=%h required=12345678", a_dout); else passed++;
    tick();
  endtask

  task automatic test_error();
    drive(16'hC000, 1'b0, 32'h0, 4'hF);
    #1;
    checks++; if (a_sen !== 4'b0000) $display("FAIL unm_sen actual=%b required=0000", a_sen); else passed++;
    tick();
    idle();
    checks++; if (a_valid !== 1'b1 || a_err !== 1'b1) $display("FAIL unm_rsp actual=%b%b required=11", a_valid, a_err); else passed++;
    checks++; if (a_dout !== 32'hDEAD_BEEF) $display("FAIL unm_dout actual=%h required=deadbeef", a_dout); else passed++;
    tick();
    checks++; if (a_err !== 1'b0) $display("FAIL unm_pulse actual=%b required=0", a_err); else passed++;
    drive(16'hC000, 1'b1, 32'h5555_5555, 4'hF);
    tick();
    idle();
    checks++; if (a_valid !== 1'b0 || a_err !== 1'b1) $display("FAIL unm_wr actual=%b%b required=01", a_valid, a_err); else passed++;
    tick();
  endtask

  task automatic test_overlap();
    sdout[2] = 32'h2222_0002;
    drive(16'h8000, 1'b0, 32'h0, 4'hF);
    #1;
    checks++; if (c_sen !== 4'b0000) $display("FAIL multi_sen actual=%b required=0000", c_sen); else passed++;
    checks++; if (a_sen !== 4'b0100) $display("FAIL s2_sen actual=%b required=0100", a_sen); else passed++;
    tick();
    idle();
    checks++; if (c_valid !== 1'b1 || c_err !== 1'b1) $display("FAIL multi_rsp actual=%b%b required=11", c_valid, c_err); else passed++;
    checks++; if (c_dout !== 32'hDEAD_BEEF) $display("FAIL multi_dout actual=%h required=deadbeef", c_dout); else passed++;
    checks++; if (a_err !== 1'b0 || a_dout !== 32'h2222_0002) $display("FAIL s2_rsp actual=%b/%h required=0/22220002", a_err, a_dout); else passed++;
    drive(16'h8800, 1'b0, 32'h0, 4'hF);
    #1;
    checks++; if (a_sen !== 4'b0000) $display("FAIL multi8800_sen actual=%b required=0000", a_sen); else passed++;
    tick();
    idle();
    checks++; if (a_err !== 1'b1) $display("FAIL multi8800_err actual=%b required=1", a_err); else passed++;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [15:0] addrs [4];
    int          sl [4];
    logic [31:0] exp_d [4];
    logic [3:0]  exp_sen;
    addrs = '{16'h0010, 16'h4020, 16'h8030, 16'h0040};
    sl    = '{0, 1, 2, 0};
    exp_d = '{32'h0000_AAAA, 32'h1111_BBBB, 32'h2222_CCCC, 32'h3333_DDDD};
    idle();
    repeat (5) tick();
    sdout[0] = 32'h0000_AAAA;
    sdout[1] = 32'h1111_BBBB;
    sdout[2] = 32'h2222_CCCC;
    for (int c = 0; c < 9; c++) begin
      if (c < 4) drive(addrs[c], 1'b0, 32'h0, 4'hF);
      else idle();
      #1;
      exp_sen = 4'b0000;
      if (c >= 1 && c <= 4) exp_sen = 4'(1) << sl[c-1];
      checks++; if (b_sen !== exp_sen) $display("FAIL b2b_sen c=%0d actual=%b required=%b", c, b_sen, exp_sen); else passed++;
      if (c >= 3) begin
        checks++;
        if (b_valid !== (c >= 4 && c <= 7)) $display("FAIL b2b_valid c=%0d actual=%b required=%b", c, b_valid, (c >= 4 && c <= 7));
        else passed++;
      end
      if (c >= 4 && c <= 7) begin
        checks++; if (b_dout !== exp_d[c-4]) $display("FAIL b2b_dout c=%0d actual=%h required=%h", c, b_dout, exp_d[c-4]); else passed++;
      end
      if (c == 8) begin
        checks++; if (b_dout !== 32'h3333_DDDD) $display("FAIL b2b_hold actual=%h required=3333dddd", b_dout); else passed++;
      end
      if (c == 4) sdout[0] = 32'h3333_DDDD;
      tick();
    end
  endtask

  task automatic test_reset_flight();
    idle();
    repeat (5) tick();
    drive(16'h4000, 1'b0, 32'h0, 4'hF);
    tick();
    drive(16'h8000, 1'b0, 32'h0, 4'hF);
    tick();
    idle();
    rst = 1'b1;
    #1;
    checks++; if (b_valid !== 1'b0 || b_sen !== 4'b0000) $display("FAIL rstf_b actual=%b/%b required=0/0000", b_valid, b_sen); else passed++;
    checks++; if (b_dout !== 32'h0 || a_dout !== 32'h0) $display("FAIL rstf_dout actual=%h/%h required=0/0", b_dout, a_dout); else passed++;
    repeat (2) tick();
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      checks++; if (b_valid !== 1'b0 || a_valid !== 1'b0) $display("FAIL rstf_drop c=%0d actual=%b%b required=00", c, b_valid, a_valid); else passed++;
      tick();
    end
    drive(16'h4000, 1'b0, 32'h0, 4'hF);
    tick();
    idle();
    repeat (2) tick();
    checks++; if (b_valid !== 1'b0) $display("FAIL rstf_early actual=%b required=0", b_valid); else passed++;
    tick();
    checks++; if (b_valid !== 1'b1 || b_dout !== 32'h1111_BBBB) $display("FAIL rstf_new actual=%b/%h required=1/1111bbbb", b_valid, b_dout); else passed++;
    tick();
  endtask

  task automatic test_err_capture();
    idle();
    err_clr = 1'b0;
    repeat (5) tick();
`ifdef SOC_DECODE_BB_ERR_CAPTURE_EN
    drive(16'hC004, 1'b0, 32'h0, 4'hF);
    #1;
    checks++; if (a_est !== 1'b0) $display("FAIL cap_pre actual=%b required=0", a_est); else passed++;
    tick();
    drive(16'hF000, 1'b0, 32'h0, 4'hF);
    tick();
    idle();
    tick();
    checks++; if (a_eaddr !== 16'hC004 || a_est !== 1'b1) $display("FAIL cap_first actual=%h/%b required=c004/1", a_eaddr, a_est); else passed++;
    drive(16'hD000, 1'b0, 32'h0, 4'hF);
    tick();
    idle();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checks++; if (a_eaddr !== 16'hD000 || a_est !== 1'b1) $display("FAIL cap_clr_new actual=%h/%b required=d000/1", a_eaddr, a_est); else passed++;
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checks++; if (a_eaddr !== 16'h0 || a_est !== 1'b0) $display("FAIL cap_clr actual=%h/%b required=0000/0", a_eaddr, a_est); else passed++;
`else
    drive(16'hC004, 1'b0, 32'h0, 4'hF);
    tick();
    idle();
    tick();
    checks++; if (a_eaddr !== 16'h0 || a_est !== 1'b0) $display("FAIL cap_off actual=%h/%b required=0000/0", a_eaddr, a_est); else passed++;
`endif
    tick();
  endtask

  initial begin
    rst     = 1'b1;
    err_clr = 1'b0;
    sdout   = '0;
    idle();
    test_reset();
    test_read();
    test_write();
    test_error();
    test_overlap();
    test_back_to_back();
    test_reset_flight();
    test_err_capture();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
